inc_accumulator: RTL and testbench



---
 rtl/inc_accumulator.sv | 89 ++++++++
 tb/tb_inc_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inc_accumulator.sv
// Purpose: sums groups of COUNT accepted samples and tracks the group maximum.
// Latency: io_out_valid rises on the edge that accepts the COUNT-th sample.
// Backpressure: result held in HOLD until io_out_ready; no input accepted meanwhile.
module inc_accumulator #(
    parameter int DATA_W = 4,
    parameter int COUNT  = 4,
    parameter int SUM_W  = 8,
    localparam int CNT_W = $clog2(COUNT) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [SUM_W-1:0]  io_out_sum,
    output logic [DATA_W-1:0] io_out_max,
    output logic [CNT_W-1:0]  io_out_count
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q,   sum_d;
    logic [DATA_W-1:0]  max_q,   max_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Handshake outputs come from the state register only; reset also
    // blocks acceptance so nothing is taken in the reset cycle.
    always_comb begin
        io_in_ready  = (state_q == ST_ACCUM) && !reset;
        io_out_valid = (state_q == ST_HOLD);
        io_out_sum   = sum_q;
        io_out_max   = max_q;
        io_out_count = cnt_q;
    end

    // Next-state logic: accumulate in ACCUM, wait for the consumer in HOLD.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (io_in_valid) begin
                    sum_d = sum_q + SUM_W'(io_in_bits);
                    max_d = (io_in_bits > max_q) ? io_in_bits : max_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(COUNT - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // No bypass: the freed slot is only usable from the next cycle.
                if (io_out_ready) begin
                    sum_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State registers with synchronous reset discarding any partial or pending group.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inc_accumulator.sv
// Purpose: directed self-checking bench for inc_accumulator (default and SUM_W=5 instances).
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: exercised by holding io_out_ready low while a result is pending.
module tb_inc_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [3:0] in_bits;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_sum;
    logic [3:0] out_max;
    logic [2:0] out_cnt;

    logic       w_in_vld;
    logic       w_in_rdy;
    logic [3:0] w_in_bits;
    logic       w_out_vld;
    logic       w_out_rdy;
    logic [4:0] w_out_sum;
    logic [3:0] w_out_max;
    logic [2:0] w_out_cnt;

    int checks   = 0;
    int failures = 0;
    int fires    = 0;
    int fires_before;

    always #5 clk = ~clk;

    inc_accumulator dut (
        .clock        (clk),
        .reset        (rst),
        .io_in_valid  (in_vld),
        .io_in_ready  (in_rdy),
        .io_in_bits   (in_bits),
        .io_out_valid (out_vld),
        .io_out_ready (out_rdy),
        .io_out_sum   (out_sum),
        .io_out_max   (out_max),
        .io_out_count (out_cnt)
    );

    inc_accumulator #(.SUM_W(5)) dut_wrap (
        .clock        (clk),
        .reset        (rst),
        .io_in_valid  (w_in_vld),
        .io_in_ready  (w_in_rdy),
        .io_in_bits   (w_in_bits),
        .io_out_valid (w_out_vld),
        .io_out_ready (w_out_rdy),
        .io_out_sum   (w_out_sum),
        .io_out_max   (w_out_max),
        .io_out_count (w_out_cnt)
    );

    // Count output fires of the default instance (never in a reset cycle).
    always @(posedge clk) begin
        if (!rst && out_vld && out_rdy) fires <= fires + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        in_vld  = 1'b1;
        in_bits = v;
        tick();
    endtask

    task automatic idle();
        in_vld  = 1'b0;
        in_bits = 4'hF;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_bits = '0; out_rdy = 1'b0;
        w_in_vld = 1'b0; w_in_bits = '0; w_out_rdy = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_valid", out_vld, 0);
        chk("rst_sum",   out_sum, 0);
        chk("rst_max",   out_max, 0);
        chk("rst_count", out_cnt, 0);
        chk("rst_ready_during_reset", in_rdy, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", in_rdy, 1);

        // Basic group 1,2,3,4 with downstream ready
        out_rdy = 1'b1;
        send(4'd1); send(4'd2); send(4'd3);
        chk("basic_partial_cnt",   out_cnt, 3);
        chk("basic_partial_sum",   out_sum, 6);
        chk("basic_partial_valid", out_vld, 0);
        send(4'd4);
        in_vld = 1'b0;
        chk("basic_valid", out_vld, 1);
        chk("basic_sum",   out_sum, 10);
        chk("basic_max",   out_max, 4);
        chk("basic_count", out_cnt, 4);
        chk("basic_ready_hold", in_rdy, 0);
        tick();
        chk("basic_valid_drop", out_vld, 0);
        chk("basic_ready_back", in_rdy, 1);
        chk("basic_sum_clear",  out_sum, 0);
        chk("basic_fires",      fires, 1);

        // Backpressure: 15,0,7,15 held for 5 cycles, valid input offered in HOLD
        out_rdy = 1'b0;
        send(4'd15); send(4'd0); send(4'd7); send(4'd15);
        in_vld = 1'b1; in_bits = 4'd3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_vld, 1);
            chk("bp_sum",   out_sum, 37);
            chk("bp_max",   out_max, 15);
            chk("bp_ready", in_rdy, 0);
            tick();
        end
        out_rdy = 1'b1;
        chk("bp_valid6", out_vld, 1);
        chk("bp_sum6",   out_sum, 37);
        chk("bp_ready6", in_rdy, 0);
        tick();
        in_vld = 1'b0;
        chk("bp_fires",     fires, 2);
        chk("bp_valid_end", out_vld, 0);
        chk("bp_no_bypass", out_sum, 0);
        chk("bp_cnt_clear", out_cnt, 0);

        // Input gaps: 5,_,_,6,_,2,9
        send(4'd5); idle(); idle(); send(4'd6); idle(); send(4'd2);
        chk("gap_cnt3",   out_cnt, 3);
        chk("gap_valid3", out_vld, 0);
        chk("gap_sum3",   out_sum, 13);
        send(4'd9);
        in_vld = 1'b0;
        chk("gap_valid", out_vld, 1);
        chk("gap_sum",   out_sum, 22);
        chk("gap_max",   out_max, 9);
        tick();
        chk("gap_fires", fires, 3);

        // Wrap on SUM_W=5 instance: 4 x 15 = 60 mod 32 = 28
        w_in_vld = 1'b1; w_in_bits = 4'd15;
        tick(); tick(); tick(); tick();
        w_in_vld = 1'b0;
        chk("wrap_valid", w_out_vld, 1);
        chk("wrap_sum",   w_out_sum, 28);
        chk("wrap_max",   w_out_max, 15);
        chk("wrap_count", w_out_cnt, 4);
        w_out_rdy = 1'b1;
        tick();
        chk("wrap_cleared", w_out_vld, 0);

        // Reset mid-group: 3,3 lost, then 1,1,1,1
        out_rdy = 1'b0;
        send(4'd3); send(4'd3);
        chk("mid_cnt2", out_cnt, 2);
        chk("mid_sum2", out_sum, 6);
        in_vld = 1'b0; rst = 1'b1;
        #1;
        chk("mid_ready_in_reset", in_rdy, 0);
        tick();
        rst = 1'b0;
        chk("mid_cnt_clear", out_cnt, 0);
        chk("mid_sum_clear", out_sum, 0);
        send(4'd1); send(4'd1); send(4'd1); send(4'd1);
        in_vld = 1'b0;
        chk("mid_valid", out_vld, 1);
        chk("mid_sum",   out_sum, 4);
        chk("mid_count", out_cnt, 4);
        chk("mid_max",   out_max, 1);

        // Reset while HOLD with downstream ready: result discarded, no fire
        fires_before = fires;
        out_rdy = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hrst_valid", out_vld, 0);
        chk("hrst_sum",   out_sum, 0);
        chk("hrst_max",   out_max, 0);
        chk("hrst_fires", fires, fires_before);
        tick();
        chk("hrst_ready", in_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
